// File: rtl/mbe_pkg.sv
// Shared constants and types for the MBE radix-4 multiplier datapath
// (booth encoder, dadda_tree and the final carry-propagate adder).
package mbe_pkg;

   localparam int PP_W    = 12;
   localparam int NUM_PP  = 6;
   localparam int PROD_W  = 22;
   localparam int FA_LO_W = 11;

   typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mbe_final_adder_if.sv
// Valid/ready stream bundle between dadda_tree, the final adder and its consumer.
// Optional zero/negative flag outputs appear when MBE_FINAL_ADDER_FLAGS_EN is defined.
interface mbe_final_adder_if
   import mbe_pkg::*;
#(
   parameter int W = PROD_W
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] carry_in;
   logic [W-1:0] sum_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] product;
`ifdef MBE_FINAL_ADDER_FLAGS_EN
   logic         zero_flag;
   logic         neg_flag;

   modport slave (
      input  in_valid, carry_in, sum_in, out_ready,
      output in_ready, out_valid, product, zero_flag, neg_flag
   );

   modport master (
      output in_valid, carry_in, sum_in, out_ready,
      input  in_ready, out_valid, product, zero_flag, neg_flag
   );
`else
   modport slave (
      input  in_valid, carry_in, sum_in, out_ready,
      output in_ready, out_valid, product
   );

   modport master (
      output in_valid, carry_in, sum_in, out_ready,
      input  in_ready, out_valid, product
   );
`endif

endinterface

// File: rtl/mbe_pipe_reg.sv
// Generic valid/ready pipeline register slice. The stage enable is computed by
// the parent; data only loads when the slice is enabled and the input is valid.
module mbe_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d,
   output logic             out_valid,
   output logic [WIDTH-1:0] q
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (en) begin
         valid_reg <= in_valid;
         if (in_valid) begin
            data_reg <= d;
         end
      end
   end

   assign out_valid = valid_reg;
   assign q         = data_reg;

endmodule

// File: rtl/mbe_final_adder.sv
// Final carry-propagate adder of the MBE multiplier: product = carry + sum mod 2^W,
// split into a registered low-half add and a high-half add. Optional flags: MBE_FINAL_ADDER_FLAGS_EN.
module mbe_final_adder
   import mbe_pkg::*;
#(
   parameter int W    = PROD_W,
   parameter int LO_W = FA_LO_W
) (
   input logic               clk,
   input logic               rst_n,
   mbe_final_adder_if.slave  bus
);

   localparam int HI_W = W - LO_W;
   // Stage-1 word: {c_mid, lo_res, hi_c, hi_s}
   localparam int S1_W = 1 + LO_W + 2 * HI_W;
`ifdef MBE_FINAL_ADDER_FLAGS_EN
   localparam int S2_W = W + 2;
`else
   localparam int S2_W = W;
`endif

   logic            s1_en;
   logic            s2_en;
   logic            s1_valid;
   logic            out_valid;
   logic [LO_W:0]   lo_sum;
   logic [S1_W-1:0] s1_d;
   logic [S1_W-1:0] s1_q;
   logic            s1_c_mid;
   logic [LO_W-1:0] s1_lo_res;
   logic [HI_W-1:0] s1_hi_c;
   logic [HI_W-1:0] s1_hi_s;
   logic [HI_W-1:0] hi_res;
   logic [W-1:0]    result;
   logic [S2_W-1:0] s2_d;
   logic [S2_W-1:0] s2_q;

   // A slot frees up whenever its downstream neighbour is empty or draining.
   assign s2_en        = !out_valid || bus.out_ready;
   assign s1_en        = !s1_valid || s2_en;
   assign bus.in_ready = s1_en;

   assign lo_sum = {1'b0, bus.carry_in[LO_W-1:0]} + {1'b0, bus.sum_in[LO_W-1:0]};
   assign s1_d   = {lo_sum, bus.carry_in[W-1:LO_W], bus.sum_in[W-1:LO_W]};

   mbe_pipe_reg #(
      .WIDTH (S1_W)
   ) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (s1_en),
      .in_valid  (bus.in_valid),
      .d         (s1_d),
      .out_valid (s1_valid),
      .q         (s1_q)
   );

   assign s1_c_mid  = s1_q[S1_W-1];
   assign s1_lo_res = s1_q[S1_W-2 -: LO_W];
   assign s1_hi_c   = s1_q[2*HI_W-1 -: HI_W];
   assign s1_hi_s   = s1_q[HI_W-1:0];

   // Carry out of the top bit is dropped: the product is modulo 2^W.
   assign hi_res = s1_hi_c + s1_hi_s + HI_W'(s1_c_mid);
   assign result = {hi_res, s1_lo_res};

`ifdef MBE_FINAL_ADDER_FLAGS_EN
   assign s2_d = {result[W-1], (result == '0), result};
`else
   assign s2_d = result;
`endif

   mbe_pipe_reg #(
      .WIDTH (S2_W)
   ) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (s2_en),
      .in_valid  (s1_valid),
      .d         (s2_d),
      .out_valid (out_valid),
      .q         (s2_q)
   );

   assign bus.out_valid = out_valid;
   assign bus.product   = s2_q[W-1:0];
`ifdef MBE_FINAL_ADDER_FLAGS_EN
   assign bus.zero_flag = s2_q[W] & out_valid;
   assign bus.neg_flag  = s2_q[W+1] & out_valid;
`endif

endmodule

// File: tb/tb_mbe_final_adder.sv
// Self-checking bench for mbe_final_adder: directed cases plus random traffic
// scored against an arithmetic reference queue.
module tb_mbe_final_adder;
   import mbe_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mbe_final_adder_if bus ();

   mbe_final_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int    checks = 0;
   int    errors = 0;
   int    n_out  = 0;
   prod_t model_q[$];
   prod_t got_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: every accepted pair yields (carry + sum) mod 2^22, in order.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            got_q.push_back(bus.product);
            $display("txn %0d product=%h", n_out, bus.product);
            if (model_q.size() == 0) begin
               check("spurious_output", 32'(bus.out_valid), 32'(0));
            end else begin
               check("stream_product", 32'(bus.product), 32'(model_q.pop_front()));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            prod_t e;
            e = bus.carry_in + bus.sum_in;
            model_q.push_back(e);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Single transfer through an empty pipeline with out_ready=1, checking latency.
   task automatic xfer(input prod_t c, input prod_t s, input prod_t exp);
      bus.carry_in = c;
      bus.sum_in   = s;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("xfer_in_ready", 32'(bus.in_ready), 32'(1));
      cyc();
      bus.in_valid = 1'b0;
      check("xfer_lat1_valid", 32'(bus.out_valid), 32'(0));
      cyc();
      check("xfer_lat2_valid", 32'(bus.out_valid), 32'(1));
      check("xfer_product", 32'(bus.product), 32'(exp));
`ifdef MBE_FINAL_ADDER_FLAGS_EN
      check("xfer_zero_flag", 32'(bus.zero_flag), 32'(exp == '0));
      check("xfer_neg_flag", 32'(bus.neg_flag), 32'(exp[PROD_W-1]));
`endif
      cyc();
      check("xfer_drop_valid", 32'(bus.out_valid), 32'(0));
   endtask

   initial begin
      int idx;
      int guard;
      int n_start;
      logic acc;

      // Reset with valid input pending
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.carry_in  = 22'($urandom);
      bus.sum_in    = 22'($urandom);
      repeat (3) cyc();
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_product", 32'(bus.product), 32'(0));
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("post_rst_idle", 32'(bus.out_valid), 32'(0));
      end

      // Directed arithmetic, including the low/high split carry and wrap
      xfer(22'h000005, 22'h00000A, 22'h00000F);
      xfer(22'h000001, 22'h0007FF, 22'h000800);
      xfer(22'h000001, 22'h3FFFFF, 22'h000000);
      xfer(22'h1FFC00, 22'h000400, 22'h200000);

      // Back-pressure: only two pairs fit while the consumer stalls
      got_q.delete();
      bus.out_ready = 1'b0;
      idx           = 1;
      for (int k = 0; k < 6; k++) begin
         bus.carry_in = 22'(idx);
         bus.sum_in   = 22'(3 * idx);
         bus.in_valid = 1'b1;
         @(negedge clk);
         acc = bus.in_ready;
         cyc();
         if (acc) idx++;
      end
      check("bp_accepts", 32'(idx - 1), 32'(2));
      check("bp_in_ready_low", 32'(bus.in_ready), 32'(0));
      check("bp_product_hold", 32'(bus.product), 32'(4));
      bus.out_ready = 1'b1;
      guard         = 0;
      while (idx <= 4 && guard < 50) begin
         bus.carry_in = 22'(idx);
         bus.sum_in   = 22'(3 * idx);
         bus.in_valid = 1'b1;
         @(negedge clk);
         acc = bus.in_ready;
         cyc();
         if (acc) idx++;
         guard++;
      end
      bus.in_valid = 1'b0;
      repeat (4) cyc();
      check("bp_count", 32'(got_q.size()), 32'(4));
      for (int k = 0; k < 4; k++) begin
         if (k < got_q.size()) check("bp_order", 32'(got_q[k]), 32'(4 * (k + 1)));
      end

      // Full throughput
      n_start = n_out;
      for (int k = 0; k < 100; k++) begin
         bus.carry_in = 22'($urandom);
         bus.sum_in   = 22'($urandom);
         bus.in_valid = 1'b1;
         @(negedge clk);
         check("tput_in_ready", 32'(bus.in_ready), 32'(1));
         if (k >= 2) check("tput_out_valid", 32'(bus.out_valid), 32'(1));
         cyc();
      end
      bus.in_valid = 1'b0;
      repeat (4) cyc();
      check("tput_count", 32'(n_out - n_start), 32'(100));

      // Random valid/ready traffic
      acc = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (!bus.in_valid || acc) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.carry_in = 22'($urandom);
            bus.sum_in   = 22'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         cyc();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      guard         = 0;
      while (model_q.size() != 0 && guard < 20) begin
         cyc();
         guard++;
      end
      check("random_drain", 32'(model_q.size()), 32'(0));

      // Mid-flight reset with two results buffered
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.carry_in = 22'($urandom);
         bus.sum_in   = 22'($urandom);
         bus.in_valid = 1'b1;
         cyc();
      end
      bus.in_valid = 1'b0;
      check("mid_full", 32'(bus.out_valid), 32'(1));
      #2;
      rst_n = 1'b0;
      model_q.delete();
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
      check("mid_rst_product", 32'(bus.product), 32'(0));
      bus.out_ready = 1'b1;
      repeat (2) cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("mid_post_idle", 32'(bus.out_valid), 32'(0));
      end

      // Flags (and plain sanity when flags are absent)
      xfer(22'h000000, 22'h000000, 22'h000000);
      xfer(22'h200000, 22'h000000, 22'h200000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mbe_final_adder.md
Name: mbe_final_adder

Overview:
- Final carry-propagate stage of the MBE radix-4 multiplier. Sits directly downstream of dadda_tree.
- Consumes the redundant carry/sum vectors (22 bits each) and produces product = carry + sum, modulo 2^22.
- Implemented as a 2-stage split adder (low half, then high half plus registered carry) with valid/ready flow control, so the top level can pipeline the multiplier.

Parameters:
- W, 22, width of the carry, sum and product vectors.
- LO_W, 11, width of the low-half adder in stage 1. High half is W-LO_W bits. Legal range 1..W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  carry_in/sum_in hold a valid pair.
- in_ready  out  1  block accepts the pair this cycle.
- carry_in  in  W  carry vector from dadda_tree.
- sum_in  in  W  sum vector from dadda_tree.
- out_valid  out  1  product holds a valid result.
- out_ready  in  1  consumer accepts product this cycle.
- product  out  W  (carry_in + sum_in) mod 2^W.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, product=0, all stage registers=0.
- Stage 1 registers (on s1_en & in_valid):
  - lo_sum = carry_in[LO_W-1:0] + sum_in[LO_W-1:0], width LO_W+1. Store its low LO_W bits as lo_res and bit LO_W as c_mid.
  - hi_c = carry_in[W-1:LO_W]; hi_s = sum_in[W-1:LO_W].
- Stage 2 (on s2_en & s1_valid): product = {hi_c + hi_s + c_mid (truncated to W-LO_W bits), lo_res}. Carry out of the top bit is discarded.
- Enables and valid updates:
  - s2_en = !out_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en (combinational, no combinational path from in_valid).
  - s1_valid <= s1_en ? in_valid : s1_valid.
  - out_valid <= s2_en ? s1_valid : out_valid.
- Latency: 2 cycles from accept (in_valid&in_ready) to out_valid. Throughput: 1 per cycle when out_ready stays high.
- Stall: with out_ready=0 and out_valid=1, product and the stage-1 registers hold. At most 2 results are buffered, then in_ready=0.
- Simultaneous accept and drain in the same cycle: no bubble and no loss.
- Data registers load only when their stage enable is high and the incoming valid is 1. When not loaded, they hold.
- Reset mid-operation: in-flight data is discarded and valids clear immediately. No partial output appears after release.
- Order is strictly preserved. No drops, no duplicates.

Optional Feature:
- Macro: MBE_FINAL_ADDER_FLAGS_EN.
- Defined:
  - Adds outputs zero_flag (1 bit, product==0) and neg_flag (1 bit, product[W-1]), registered alongside product.
  - Both reset to 0 and are qualified by out_valid.
  - zero_flag is computed in stage 2 from the final product value.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package mbe_pkg:
  - constants PP_W=12, NUM_PP=6, PROD_W=22, FA_LO_W=11.
  - typedef prod_t (logic [PROD_W-1:0]).
  - Shared with dadda_tree and the top entity.
- One natural sub-module: mbe_pipe_reg, a generic valid/ready pipeline register (WIDTH parameter). Instantiated twice, once per stage. The adders stay inline.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and arbitrary inputs -> out_valid=0, product=0, no output for 2 cycles after release.
- Basic: carry_in=22'h000005, sum_in=22'h00000A, out_ready=1 -> accepted at cycle t, out_valid at t+2 with product=22'h00000F, then out_valid drops.
- Split carry: carry_in=22'h000001, sum_in=22'h0007FF -> product=22'h000800 (c_mid propagates into high half). Then carry_in=22'h000001, sum_in=22'h3FFFFF -> product=22'h000000 (wrap mod 2^22).
- Back-pressure: stream 4 pairs (i, 3i) for i=1..4 with out_ready=0 -> in_ready drops after 2 accepts. Release out_ready -> products 4, 8, 12, 16 in order, no loss or duplication.
- Full throughput: 100 random pairs, in_valid and out_ready held 1 -> one result per cycle, each equal to (carry+sum) mod 2^22 vs scoreboard.
- Mid-flight reset: assert rst_n=0 while 2 results are in flight -> out_valid=0 asynchronously, and nothing is emitted after release until new input is accepted. With MBE_FINAL_ADDER_FLAGS_EN, product 0 gives zero_flag=1, and product 22'h200000 gives neg_flag=1.
